// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Define OTTER_ARB_FAIRNESS_EN to force a fetch grant once STARVE_MAX data grants have bypassed it.
module otter_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    output logic        IF_VALID,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    input  logic        D_SIGN,
    output logic [31:0] D_RDATA,
    output logic        D_VALID,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_DIN,
    output logic        MEM_WE,
    output logic        MEM_RE,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT,
    output logic        STALL_IF,
    output logic        STALL_MEM
);

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign;
    logic        r_if_valid;
    logic        r_d_valid;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic [7:0]  r_starve;

    logic w_busy;
    logic w_force_if;
    logic w_grant_d;
    logic w_grant_if;

    assign w_busy = (r_state != IDLE);

`ifdef OTTER_ARB_FAIRNESS_EN
    assign w_force_if = IF_REQ && (r_starve == STARVE_LIM);
`else
    assign w_force_if = 1'b0;
`endif

    // Grants are only made from IDLE; data wins unless fetch has been starved too long.
    assign w_grant_d  = !w_busy && D_REQ && !w_force_if;
    assign w_grant_if = !w_busy && IF_REQ && !w_grant_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = BUSY_D;
                end else if (w_grant_if) begin
                    w_next_state = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        MEM_ADDR = 32'd0;
        MEM_DIN  = 32'd0;
        MEM_WE   = 1'b0;
        MEM_RE   = 1'b0;
        MEM_SIZE = 2'b00;
        MEM_SIGN = 1'b0;
        case (r_state)
            BUSY_IF: begin
                MEM_ADDR = r_addr;
                MEM_SIZE = 2'b10;
                MEM_RE   = 1'b1;
            end
            BUSY_D: begin
                MEM_ADDR = r_addr;
                MEM_DIN  = r_wdata;
                MEM_SIZE = r_size;
                MEM_SIGN = r_sign;
                MEM_WE   = r_we;
                MEM_RE   = !r_we;
            end
            default: ;
        endcase
    end

    // Latch attributes on grant, count down the latency, and capture read data on the final cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_sign     <= 1'b0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            if (w_grant_d) begin
                r_cnt   <= LAT_LOAD;
                r_addr  <= D_ADDR;
                r_wdata <= D_WDATA;
                r_we    <= D_WE;
                r_size  <= D_SIZE;
                r_sign  <= D_SIGN;
            end else if (w_grant_if) begin
                r_cnt  <= LAT_LOAD;
                r_addr <= IF_ADDR;
            end else if (w_busy) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (r_state == BUSY_IF) begin
                    r_if_rdata <= MEM_DOUT;
                    r_if_valid <= 1'b1;
                end else begin
                    r_d_valid <= 1'b1;
                    if (!r_we) begin
                        r_d_rdata <= MEM_DOUT;
                    end
                end
            end
        end
    end

    // Saturating count of data grants that went ahead while a fetch was waiting.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_starve <= 8'd0;
        end else if (w_grant_if) begin
            r_starve <= 8'd0;
        end else if (w_grant_d && IF_REQ && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    assign IF_RDATA  = r_if_rdata;
    assign IF_VALID  = r_if_valid;
    assign D_RDATA   = r_d_rdata;
    assign D_VALID   = r_d_valid;
    assign STALL_IF  = IF_REQ & ~r_if_valid;
    assign STALL_MEM = D_REQ & ~r_d_valid;

endmodule
